// File: rtl/ahbl_slave_mem_if.sv
// rtl/ahbl_slave_mem_if.sv - AHB-Lite bus bundle between a master/interconnect and ahbl_slave_mem
interface ahbl_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_slave_mem.sv
// rtl/ahbl_slave_mem.sv - AHB-Lite memory responder with wait states and two-cycle ERROR
module ahbl_slave_mem #(
  parameter int AWIDTH      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic           HCLK,
  input  logic           HRESETN,
  ahbl_slave_mem_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        wait_cnt;
  logic [AWIDTH+1:0] lat_addr;
  logic              lat_write;
  logic [1:0]        lat_size;
  logic [3:0]        byte_en;
  logic              open;
  logic              accept;
  logic              illegal;
  logic              hreadyout;
  logic              hresp;
  logic [AWIDTH-1:0] lat_word;

  logic [31:0] mem [DEPTH];

  // Bus attributes this responder does not act on.
  logic unused_inputs;
  assign unused_inputs = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR[31:AWIDTH+2]};

  // A new address phase can only be taken in a cycle where this slave is ready.
  assign open     = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept   = open && bus.HSEL && bus.HTRANS[1] && bus.HREADY;
  assign illegal  = (bus.HSIZE > 3'b010)
                 || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                 || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
  assign lat_word = lat_addr[AWIDTH+1:2];

  // State register, wait counter and latched address-phase attributes.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_size  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_addr  <= bus.HADDR[AWIDTH+1:0];
        lat_write <= bus.HWRITE;
        lat_size  <= bus.HSIZE[1:0];
        wait_cnt  <= illegal ? 4'd0 : WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Next state and the ready/response pair decoded from the current state.
  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        hresp = (state == ST_ERR2);
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_nxt = ST_DATA;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Little-endian lane enables for the transfer currently in its data phase.
  always_comb begin
    byte_en = 4'b0000;
    case (lat_size)
      2'b00:   byte_en[lat_addr[1:0]] = 1'b1;
      2'b01:   byte_en = lat_addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Write commits on the completion edge; the array itself is never reset.
  always_ff @(posedge HCLK) begin
    if ((state == ST_DATA) && lat_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[lat_word][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = ((state == ST_DATA) && !lat_write) ? mem[lat_word] : 32'h0;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// tb/tb_ahbl_slave_mem.sv - randomized model-checked bench for ahbl_slave_mem at 0, 2 and 3 wait states
module tb_ahbl_slave_mem;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic        HCLK;
  logic        HRESETN;
  logic [2:0]  sel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;

  logic [2:0]  rdy_v;
  logic [2:0]  resp_v;
  logic [31:0] rdata_v [3];

  int errors = 0;
  int checks = 0;

  beat_t       seq[$];
  logic [31:0] rd_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem [3][1024];

  ahbl_slave_mem_if bus0();
  ahbl_slave_mem_if bus2();
  ahbl_slave_mem_if bus3();

  assign bus0.HSEL = sel_v[0];   assign bus2.HSEL = sel_v[1];   assign bus3.HSEL = sel_v[2];
  assign bus0.HADDR = haddr;     assign bus2.HADDR = haddr;     assign bus3.HADDR = haddr;
  assign bus0.HTRANS = htrans;   assign bus2.HTRANS = htrans;   assign bus3.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;   assign bus2.HWRITE = hwrite;   assign bus3.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;     assign bus2.HSIZE = hsize;     assign bus3.HSIZE = hsize;
  assign bus0.HBURST = hburst;   assign bus2.HBURST = hburst;   assign bus3.HBURST = hburst;
  assign bus0.HPROT = hprot;     assign bus2.HPROT = hprot;     assign bus3.HPROT = hprot;
  assign bus0.HMASTLOCK = hmastlock; assign bus2.HMASTLOCK = hmastlock; assign bus3.HMASTLOCK = hmastlock;
  assign bus0.HWDATA = hwdata;   assign bus2.HWDATA = hwdata;   assign bus3.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  assign rdy_v  = {bus3.HREADYOUT, bus2.HREADYOUT, bus0.HREADYOUT};
  assign resp_v = {bus3.HRESP, bus2.HRESP, bus0.HRESP};
  assign rdata_v[0] = bus0.HRDATA;
  assign rdata_v[1] = bus2.HRDATA;
  assign rdata_v[2] = bus3.HRDATA;

  ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESETN(HRESETN), .bus(bus0));
  ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(2)) dut2 (.HCLK(HCLK), .HRESETN(HRESETN), .bus(bus2));
  ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(3)) dut3 (.HCLK(HCLK), .HRESETN(HRESETN), .bus(bus3));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    return (a % (32'd1 << s)) == 32'd0;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int w;
    int first;
    int n;
    w = widx(a);
    first = int'(a[1:0]);
    n = 1 << s;
    for (int b = first; b < first + n; b++) begin
      ref_mem[d][w][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic add(input bit s, input logic [1:0] t, input logic [31:0] a, input bit w,
                     input logic [2:0] sz, input logic [31:0] wd);
    beat_t b;
    b.sel = s; b.trans = t; b.addr = a; b.write = w; b.size = sz; b.wdata = wd;
    seq.push_back(b);
  endtask

  task automatic drive_idle();
    sel_v = 3'b000; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b000;
  endtask

  task automatic drive_addr(input int d, input beat_t b);
    sel_v = 3'b000;
    sel_v[d] = b.sel;
    haddr = b.addr; htrans = b.trans; hwrite = b.write; hsize = b.size;
    hburst = 3'($urandom_range(0, 7)); hprot = 4'($urandom_range(0, 15)); hmastlock = 1'($urandom_range(0, 1));
  endtask

  // Plays the queued beats as a pipelined master and checks every data-phase cycle.
  task automatic run_seq(input int d);
    int ai;
    bit dv;
    beat_t db;
    int k;
    bit xfer, completing;
    logic exp_rdy, exp_resp, o_rdy, o_resp;
    logic [31:0] exp_rd, o_rd;
    ai = 0; dv = 1'b0; k = 0;
    db = '{default: '0};
    while (ai < seq.size() || dv) begin
      if (ai < seq.size()) drive_addr(d, seq[ai]); else drive_idle();
      hwdata = dv ? db.wdata : $urandom;
      @(negedge HCLK);
      o_rdy = rdy_v[d]; o_resp = resp_v[d]; o_rd = rdata_v[d];
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'h0; completing = 1'b0;
      if (dv) begin
        xfer = db.sel && db.trans[1];
        if (xfer && is_legal(db.addr, db.size)) begin
          if (k < ws_of(d)) begin
            exp_rdy = 1'b0;
          end else begin
            completing = 1'b1;
            if (!db.write) exp_rd = ref_mem[d][widx(db.addr)];
          end
        end else if (xfer) begin
          exp_resp = 1'b1;
          exp_rdy = (k >= 1);
        end
      end
      checks++;
      if (o_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL hreadyout dut%0d addr=%h k=%0d: got %b want %b", d, db.addr, k, o_rdy, exp_rdy);
      end
      checks++;
      if (o_resp !== exp_resp) begin
        errors++;
        $display("FAIL hresp dut%0d addr=%h k=%0d: got %b want %b", d, db.addr, k, o_resp, exp_resp);
      end
      checks++;
      if (o_rd !== exp_rd) begin
        errors++;
        $display("FAIL hrdata dut%0d addr=%h k=%0d: got %h want %h", d, db.addr, k, o_rd, exp_rd);
      end
      @(posedge HCLK);
      #1;
      if (o_rdy === 1'b1) begin
        if (completing && db.write) model_write(d, db.addr, db.size, db.wdata);
        if (completing && !db.write) rd_q.push_back(o_rd);
        if (dv && db.sel && db.trans[1]) lat_q.push_back(k + 1);
        dv = (ai < seq.size());
        if (dv) db = seq[ai];
        ai++;
        k = 0;
      end else begin
        k++;
        if (k > 40) begin
          checks++;
          errors++;
          $display("FAIL timeout dut%0d addr=%h: hreadyout stuck low", d, db.addr);
          break;
        end
      end
    end
    seq.delete();
    drive_idle();
  endtask

  task automatic test_reset();
    HRESETN = 1'b1;
    drive_idle();
    hwdata = 32'h0; hburst = 3'b000; hprot = 4'h0; hmastlock = 1'b0;
    #2 HRESETN = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy_v[d] !== 1'b1) begin errors++; $display("FAIL reset_hreadyout dut%0d: got %b want 1", d, rdy_v[d]); end
      checks++;
      if (resp_v[d] !== 1'b0) begin errors++; $display("FAIL reset_hresp dut%0d: got %b want 0", d, resp_v[d]); end
      checks++;
      if (rdata_v[d] !== 32'h0) begin errors++; $display("FAIL reset_hrdata dut%0d: got %h want 0", d, rdata_v[d]); end
    end
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETN = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_word_rw();
    rd_q.delete();
    add(1, 2'b10, 32'h10, 1, 3'b010, 32'hDEADBEEF);
    add(1, 2'b10, 32'h10, 0, 3'b010, 32'h0);
    run_seq(0);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_rw: got %h want deadbeef", (rd_q.size() > 0) ? rd_q[0] : 32'hx);
    end
  endtask

  task automatic test_byte_lanes();
    rd_q.delete();
    add(1, 2'b10, 32'h20, 1, 3'b000, 32'h00000011);
    add(1, 2'b10, 32'h21, 1, 3'b000, 32'h00002200);
    add(1, 2'b10, 32'h22, 1, 3'b000, 32'h00330000);
    add(1, 2'b10, 32'h23, 1, 3'b000, 32'h44000000);
    add(1, 2'b10, 32'h22, 1, 3'b001, 32'hAA550000);
    add(1, 2'b10, 32'h20, 0, 3'b010, 32'h0);
    run_seq(0);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== 32'hAA552211) begin
      errors++;
      $display("FAIL byte_lanes: got %h want aa552211", (rd_q.size() > 0) ? rd_q[0] : 32'hx);
    end
  endtask

  task automatic test_wait_states();
    lat_q.delete();
    add(1, 2'b10, 32'h30, 1, 3'b010, 32'h5A5A0F0F);
    add(1, 2'b10, 32'h30, 0, 3'b010, 32'h0);
    add(1, 2'b10, 32'h34, 1, 3'b010, $urandom);
    run_seq(1);
    checks++;
    if (lat_q.size() != 3) begin
      errors++;
      $display("FAIL ws2_count: got %0d transfers want 3", lat_q.size());
    end
    foreach (lat_q[i]) begin
      checks++;
      if (lat_q[i] != 3) begin
        errors++;
        $display("FAIL ws2_cycles beat%0d: got %0d want 3", i, lat_q[i]);
      end
    end
  endtask

  task automatic test_errors();
    rd_q.delete();
    add(1, 2'b10, 32'h40, 1, 3'b010, 32'h11223344);
    add(1, 2'b10, 32'h42, 1, 3'b010, 32'hFFFFFFFF);
    add(1, 2'b10, 32'h41, 1, 3'b001, 32'hFFFFFFFF);
    add(1, 2'b10, 32'h40, 1, 3'b011, 32'hFFFFFFFF);
    add(1, 2'b10, 32'h40, 0, 3'b010, 32'h0);
    run_seq(0);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== 32'h11223344) begin
      errors++;
      $display("FAIL error_no_write: got %h want 11223344", (rd_q.size() > 0) ? rd_q[0] : 32'hx);
    end
  endtask

  task automatic test_burst_busy();
    add(1, 2'b10, 32'h80, 1, 3'b010, $urandom);
    add(1, 2'b11, 32'h84, 1, 3'b010, $urandom);
    add(1, 2'b01, 32'h88, 1, 3'b010, $urandom);
    add(1, 2'b11, 32'h88, 1, 3'b010, $urandom);
    add(1, 2'b11, 32'h8C, 1, 3'b010, $urandom);
    add(1, 2'b10, 32'h80, 0, 3'b010, 32'h0);
    add(1, 2'b11, 32'h84, 0, 3'b010, 32'h0);
    add(1, 2'b11, 32'h88, 0, 3'b010, 32'h0);
    add(1, 2'b11, 32'h8C, 0, 3'b010, 32'h0);
    run_seq(0);
  endtask

  task automatic test_random(input int d);
    for (int i = 0; i < 16; i++) add(1, 2'b10, 32'h100 + 32'(4 * i), 1, 3'b010, $urandom);
    for (int i = 0; i < 48; i++) begin
      add(($urandom % 8) != 0, 2'($urandom_range(0, 3)), 32'h100 + 32'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)),
          (($urandom % 8) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)), $urandom);
    end
    for (int i = 0; i < 16; i++) add(1, 2'b10, 32'h100 + 32'(4 * i), 0, 3'b010, 32'h0);
    run_seq(d);
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    old = $urandom;
    rd_q.delete();
    add(1, 2'b10, 32'h60, 1, 3'b010, old);
    run_seq(2);
    sel_v = 3'b100; haddr = 32'h60; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge HCLK);
    #1;
    drive_idle();
    hwdata = ~old;
    @(posedge HCLK);
    #1;
    checks++;
    if (rdy_v[2] !== 1'b0) begin errors++; $display("FAIL mid_wait_hreadyout: got %b want 0", rdy_v[2]); end
    #2 HRESETN = 1'b0;
    #1;
    checks++;
    if (rdy_v[2] !== 1'b1) begin errors++; $display("FAIL mid_reset_hreadyout: got %b want 1", rdy_v[2]); end
    checks++;
    if (resp_v[2] !== 1'b0) begin errors++; $display("FAIL mid_reset_hresp: got %b want 0", resp_v[2]); end
    checks++;
    if (rdata_v[2] !== 32'h0) begin errors++; $display("FAIL mid_reset_hrdata: got %h want 0", rdata_v[2]); end
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETN = 1'b1;
    @(posedge HCLK);
    #1;
    add(1, 2'b10, 32'h60, 0, 3'b010, 32'h0);
    run_seq(2);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== old) begin
      errors++;
      $display("FAIL mid_reset_keep: got %h want %h", (rd_q.size() > 0) ? rd_q[0] : 32'hx, old);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_burst_busy();
    for (int d = 0; d < 3; d++) test_random(d);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
